// File: rtl/jic_pkg.sv
// ---------------------------------------------------------------------------
// jic_pkg
// Shared definitions for the jump / interrupt control block:
//   - 5-bit opcode encodings decoded from the top of the instruction word
//   - interrupt FSM state type
// Optional feature macro used by importers: JIC_CALL_STACK_EN
// ---------------------------------------------------------------------------
package jic_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_JMP  = 5'b11000;
    localparam logic [OP_W-1:0] OP_JZ   = 5'b11110;
    localparam logic [OP_W-1:0] OP_JNZ  = 5'b11111;
    localparam logic [OP_W-1:0] OP_JC   = 5'b11100;
    localparam logic [OP_W-1:0] OP_JNC  = 5'b11101;
    localparam logic [OP_W-1:0] OP_RETI = 5'b10000;
    localparam logic [OP_W-1:0] OP_CALL = 5'b11001;
    localparam logic [OP_W-1:0] OP_RET  = 5'b11010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ISR  = 1'b1
    } jic_state_e;

endpackage

// File: rtl/jic_ret_stack.sv
// ---------------------------------------------------------------------------
// jic_ret_stack
// DEPTH x W LIFO holding CALL return addresses. Only instantiated when
// JIC_CALL_STACK_EN is defined. Push into a full stack and pop from an empty
// stack are ignored here; the parent flags them as errors.
// Ports:
//   clk, reset_n  clock / async active-low reset (clears the pointer only)
//   push_i        write data_i on top
//   pop_i         remove top entry
//   data_i        value to push
//   top_o         current top entry (meaningless when empty_o)
//   full_o        DEPTH entries held
//   empty_o       no entries held
// ---------------------------------------------------------------------------
module jic_ret_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] top_idx;

    assign wr_idx  = cnt_q[PTR_W-1:0];
    assign top_idx = cnt_q[PTR_W-1:0] - PTR_W'(1);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign top_o   = mem_q[top_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (push_i && !full_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // NOTE: storage has no reset; the count alone defines which entries are
    // valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/jump_int_ctrl.sv
// ---------------------------------------------------------------------------
// jump_int_ctrl
// Combinational jump decode plus a registered interrupt entry/return FSM with
// shadow return-address/flag registers and a one-deep pending-interrupt latch.
// Optional macro JIC_CALL_STACK_EN adds CALL/RET with a hardware return stack
// and a sticky stk_err; without it CALL/RET are no-ops and stk_err is 0.
// Ports:
//   clk, reset_n      clock / async active-low reset
//   ins               instruction in decode (opcode in top 5 bits)
//   current_address   address ins was fetched from
//   flag_ex           flags from execute
//   interrupt         level request; a rising edge requests service
//   jmp_loc           PC load value (0 when pc_mux_sel is 0)
//   pc_mux_sel        PC loads jmp_loc this cycle
//   flag_restore      saved flags, valid with flag_restore_en
//   flag_restore_en   one-cycle strobe on RETI
//   int_ack           one-cycle strobe on ISR entry
//   in_isr            servicing an interrupt
//   stk_err           sticky stack over/underflow
// ---------------------------------------------------------------------------
module jump_int_ctrl
    import jic_pkg::*;
#(
    parameter int unsigned        INS_W     = 20,
    parameter int unsigned        ADDR_W    = 8,
    parameter int unsigned        FLAG_W    = 4,
    parameter int unsigned        ZF_BIT    = 1,
    parameter int unsigned        CF_BIT    = 0,
    parameter logic [ADDR_W-1:0]  ISR_ADDR  = 8'hF0,
    parameter int unsigned        STK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [INS_W-1:0]  ins,
    input  logic [ADDR_W-1:0] current_address,
    input  logic [FLAG_W-1:0] flag_ex,
    input  logic              interrupt,
    output logic [ADDR_W-1:0] jmp_loc,
    output logic              pc_mux_sel,
    output logic [FLAG_W-1:0] flag_restore,
    output logic              flag_restore_en,
    output logic              int_ack,
    output logic              in_isr,
    output logic              stk_err
);

    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] target;
    logic              cond_jump;
    logic              stk_jump;
    logic [ADDR_W-1:0] stk_loc;

    jic_state_e        state_q;
    logic              int_q;
    logic              pend_q;
    logic [ADDR_W-1:0] ret_addr_q;
    logic [FLAG_W-1:0] ret_flag_q;

    logic              irq_edge;
    logic              entry;
    logic              reti;

    assign opcode = ins[INS_W-1 -: OP_W];
    assign target = ins[ADDR_W-1:0];

    // Bits between opcode and target carry no meaning for this block.
    logic unused_ins;
    assign unused_ins = ^ins[INS_W-OP_W-1:ADDR_W];

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cond_jump = 1'b0;
        unique case (opcode)
            OP_JMP:  cond_jump = 1'b1;
            OP_JZ:   cond_jump =  flag_ex[ZF_BIT];
            OP_JNZ:  cond_jump = !flag_ex[ZF_BIT];
            OP_JC:   cond_jump =  flag_ex[CF_BIT];
            OP_JNC:  cond_jump = !flag_ex[CF_BIT];
            default: cond_jump = 1'b0;
        endcase
    end

    assign irq_edge = interrupt & ~int_q;
    assign entry    = (state_q == ST_IDLE) & (irq_edge | pend_q);
    assign reti     = (state_q == ST_ISR) & (opcode == OP_RETI);
    assign in_isr   = (state_q == ST_ISR);

`ifdef JIC_CALL_STACK_EN
    logic              is_call;
    logic              is_ret;
    logic              push_req;
    logic              pop_req;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;
    logic              stk_err_q;

    assign is_call  = (opcode == OP_CALL);
    assign is_ret   = (opcode == OP_RET);
    // ISR entry takes the PC this cycle, so the stack must not move.
    assign push_req = is_call & ~entry;
    assign pop_req  = is_ret  & ~entry;

    jic_ret_stack #(
        .DEPTH (STK_DEPTH),
        .W     (ADDR_W)
    ) u_ret_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_req),
        .pop_i   (pop_req),
        .data_i  (current_address + ADDR_W'(1)),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    // CALL jumps even on overflow; RET from an empty stack does not jump.
    assign stk_jump = is_call | (is_ret & ~stk_empty);
    assign stk_loc  = is_ret ? stk_top : target;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stk_err_q <= 1'b0;
        end else if ((push_req && stk_full) || (pop_req && stk_empty)) begin
            stk_err_q <= 1'b1;
        end
    end

    assign stk_err = stk_err_q;
`else
    assign stk_jump = 1'b0;
    assign stk_loc  = '0;
    assign stk_err  = 1'b0;
`endif

    // Priority: ISR entry, then RETI, then ordinary/stack jumps.
    always_comb begin
        pc_mux_sel      = 1'b0;
        jmp_loc         = '0;
        int_ack         = 1'b0;
        flag_restore    = '0;
        flag_restore_en = 1'b0;
        if (entry) begin
            pc_mux_sel = 1'b1;
            jmp_loc    = ISR_ADDR;
            int_ack    = 1'b1;
        end else if (reti) begin
            pc_mux_sel      = 1'b1;
            jmp_loc         = ret_addr_q;
            flag_restore    = ret_flag_q;
            flag_restore_en = 1'b1;
        end else if (cond_jump) begin
            pc_mux_sel = 1'b1;
            jmp_loc    = target;
        end else if (stk_jump) begin
            pc_mux_sel = 1'b1;
            jmp_loc    = stk_loc;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            int_q      <= 1'b0;
            pend_q     <= 1'b0;
            ret_addr_q <= '0;
            ret_flag_q <= '0;
        end else begin
            int_q <= interrupt;
            unique case (state_q)
                ST_IDLE: begin
                    if (entry) begin
                        // A taken jump in the interrupted slot resumes at its
                        // target; otherwise the instruction is re-fetched.
                        ret_addr_q <= cond_jump ? target : current_address;
                        ret_flag_q <= flag_ex;
                        pend_q     <= 1'b0;
                        state_q    <= ST_ISR;
                    end
                end
                ST_ISR: begin
                    if (irq_edge) begin
                        pend_q <= 1'b1;
                    end
                    if (reti) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jump_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jump_int_ctrl
// Directed stimulus for jump_int_ctrl. A behavioural model (flags, ISR flag,
// pending flag, saved return context, return-address queue) predicts every
// output each cycle; a compare process checks all outputs on each falling
// edge. Hand-computed literal checks pin the model at key points.
// CALL/RET scenarios run only when JIC_CALL_STACK_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jump_int_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [19:0] ins = '0;
    logic [7:0]  current_address = '0;
    logic [3:0]  flag_ex = '0;
    logic        interrupt = 1'b0;
    logic [7:0]  jmp_loc;
    logic        pc_mux_sel;
    logic [3:0]  flag_restore;
    logic        flag_restore_en;
    logic        int_ack;
    logic        in_isr;
    logic        stk_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jump_int_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ins             (ins),
        .current_address (current_address),
        .flag_ex         (flag_ex),
        .interrupt       (interrupt),
        .jmp_loc         (jmp_loc),
        .pc_mux_sel      (pc_mux_sel),
        .flag_restore    (flag_restore),
        .flag_restore_en (flag_restore_en),
        .int_ack         (int_ack),
        .in_isr          (in_isr),
        .stk_err         (stk_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] mk(input logic [4:0] op, input logic [7:0] tgt);
        return {op, 7'b0, tgt};
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       sel;
        logic [7:0] loc;
        logic       ack;
        logic [3:0] fr;
        logic       fre;
    } exp_t;

    bit         m_in_isr   = 0;
    bit         m_pend     = 0;
    bit         m_prev_int = 0;
    logic [7:0] m_ret_addr = '0;
    logic [3:0] m_ret_flag = '0;
    bit         m_err      = 0;
    logic [7:0] m_stk[$];

    function automatic bit plain_jump_taken();
        case (ins[19:15])
            5'b11000: return 1'b1;
            5'b11110: return flag_ex[1];
            5'b11111: return !flag_ex[1];
            5'b11100: return flag_ex[0];
            5'b11101: return !flag_ex[0];
            default:  return 1'b0;
        endcase
    endfunction

    function automatic bit model_entry();
        return !m_in_isr && ((interrupt && !m_prev_int) || m_pend);
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e = '0;
        if (model_entry()) begin
            e.sel = 1; e.loc = 8'hF0; e.ack = 1;
        end else if (m_in_isr && ins[19:15] == 5'b10000) begin
            e.sel = 1; e.loc = m_ret_addr; e.fr = m_ret_flag; e.fre = 1;
        end else if (plain_jump_taken()) begin
            e.sel = 1; e.loc = ins[7:0];
        end
`ifdef JIC_CALL_STACK_EN
        else if (ins[19:15] == 5'b11001) begin
            e.sel = 1; e.loc = ins[7:0];
        end else if (ins[19:15] == 5'b11010 && m_stk.size() > 0) begin
            e.sel = 1; e.loc = m_stk[$];
        end
`endif
        return e;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_in_isr = 0; m_pend = 0; m_prev_int = 0;
            m_ret_addr = '0; m_ret_flag = '0; m_err = 0;
            m_stk.delete();
        end else begin
            if (model_entry()) begin
                m_ret_addr = plain_jump_taken() ? ins[7:0] : current_address;
                m_ret_flag = flag_ex;
                m_pend     = 0;
                m_in_isr   = 1;
            end else begin
                if (m_in_isr) begin
                    if (interrupt && !m_prev_int) m_pend = 1;
                    if (ins[19:15] == 5'b10000) m_in_isr = 0;
                end
`ifdef JIC_CALL_STACK_EN
                if (ins[19:15] == 5'b11001) begin
                    if (m_stk.size() == 4) m_err = 1;
                    else m_stk.push_back(current_address + 8'd1);
                end else if (ins[19:15] == 5'b11010) begin
                    if (m_stk.size() == 0) m_err = 1;
                    else void'(m_stk.pop_back());
                end
`endif
            end
            m_prev_int = interrupt;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = predict();
        check("pc_mux_sel",      32'(pc_mux_sel),      32'(e.sel));
        check("jmp_loc",         32'(jmp_loc),         32'(e.loc));
        check("int_ack",         32'(int_ack),         32'(e.ack));
        check("flag_restore",    32'(flag_restore),    32'(e.fr));
        check("flag_restore_en", 32'(flag_restore_en), 32'(e.fre));
        check("in_isr",          32'(in_isr),          32'(m_in_isr));
        check("stk_err",         32'(stk_err),         32'(m_err));
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic [19:0] i, input logic [7:0] a, input logic [3:0] f,
                       input logic irq);
        @(posedge clk);
        #1;
        ins = i; current_address = a; flag_ex = f; interrupt = irq;
        @(negedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_sel"}, 32'(pc_mux_sel), 32'd0);
        check({tag, "_loc"}, 32'(jmp_loc),    32'd0);
        check({tag, "_ack"}, 32'(int_ack),    32'd0);
        check({tag, "_isr"}, 32'(in_isr),     32'd0);
        check({tag, "_fre"}, 32'(flag_restore_en), 32'd0);
        check({tag, "_err"}, 32'(stk_err),    32'd0);
    endtask

    localparam logic [4:0] NOP = 5'b00000;

    initial begin
        repeat (2) @(negedge clk);
        #1;
        all_zero("reset");
        @(posedge clk); #1; reset_n = 1'b1;

        // Conditional jumps
        cyc(mk(5'b11110, 8'h3C), 8'h01, 4'b0010, 0);
        check("jz_taken_sel", 32'(pc_mux_sel), 32'd1);
        check("jz_taken_loc", 32'(jmp_loc), 32'h3C);
        cyc(mk(5'b11110, 8'h3C), 8'h02, 4'b0000, 0);
        check("jz_not_sel", 32'(pc_mux_sel), 32'd0);
        check("jz_not_loc", 32'(jmp_loc), 32'd0);
        cyc(mk(5'b11111, 8'h55), 8'h03, 4'b0000, 0);
        cyc(mk(5'b11111, 8'h55), 8'h04, 4'b0010, 0);
        cyc(mk(5'b11100, 8'h66), 8'h05, 4'b0001, 0);
        check("jc_taken_loc", 32'(jmp_loc), 32'h66);
        cyc(mk(5'b11100, 8'h66), 8'h06, 4'b1110, 0);
        cyc(mk(5'b11101, 8'h77), 8'h07, 4'b1110, 0);
        cyc(mk(5'b11101, 8'h77), 8'h08, 4'b0001, 0);
        cyc(mk(5'b11000, 8'hA5), 8'h09, 4'b0000, 0);
        cyc(mk(5'b10101, 8'hA5), 8'h0A, 4'b1111, 0);
        check("unknown_op_sel", 32'(pc_mux_sel), 32'd0);
        // RETI in IDLE is ignored
        cyc(mk(5'b10000, 8'h00), 8'h0B, 4'b1111, 0);
        check("reti_idle_sel", 32'(pc_mux_sel), 32'd0);
        check("reti_idle_fre", 32'(flag_restore_en), 32'd0);

        // Interrupt entry and return
        cyc(mk(NOP, 8'h00), 8'h12, 4'b0101, 1);
        check("entry_sel", 32'(pc_mux_sel), 32'd1);
        check("entry_loc", 32'(jmp_loc), 32'hF0);
        check("entry_ack", 32'(int_ack), 32'd1);
        cyc(mk(NOP, 8'h00), 8'hF0, 4'b0000, 1);
        check("in_isr_set", 32'(in_isr), 32'd1);
        check("ack_once", 32'(int_ack), 32'd0);
        cyc(mk(5'b10000, 8'h00), 8'hF1, 4'b0000, 0);
        check("reti_loc", 32'(jmp_loc), 32'h12);
        check("reti_flag", 32'(flag_restore), 32'h5);
        check("reti_fre", 32'(flag_restore_en), 32'd1);
        cyc(mk(NOP, 8'h00), 8'h12, 4'b0000, 0);
        check("in_isr_clr", 32'(in_isr), 32'd0);

        // Edge coinciding with a taken JMP: ISR wins, return goes to target
        cyc(mk(5'b11000, 8'h40), 8'h20, 4'b0011, 1);
        check("edge_jmp_loc", 32'(jmp_loc), 32'hF0);
        cyc(mk(5'b11000, 8'h99), 8'hF0, 4'b0000, 0);
        check("isr_jmp_loc", 32'(jmp_loc), 32'h99);
        cyc(mk(5'b10000, 8'h00), 8'hF1, 4'b0000, 0);
        check("reti_jmp_tgt", 32'(jmp_loc), 32'h40);
        check("reti_jmp_flag", 32'(flag_restore), 32'h3);

        // Pending interrupt: 2nd edge latched, 3rd edge dropped
        cyc(mk(NOP, 8'h00), 8'h30, 4'b1000, 1);
        cyc(mk(NOP, 8'h00), 8'hF0, 4'b0000, 0);
        cyc(mk(NOP, 8'h00), 8'hF1, 4'b0000, 1);
        cyc(mk(NOP, 8'h00), 8'hF2, 4'b0000, 0);
        cyc(mk(NOP, 8'h00), 8'hF3, 4'b0000, 1);
        cyc(mk(5'b10000, 8'h00), 8'hF4, 4'b0000, 0);
        check("b2b_reti_loc", 32'(jmp_loc), 32'h30);
        cyc(mk(NOP, 8'h00), 8'h31, 4'b0110, 0);
        check("b2b_entry_loc", 32'(jmp_loc), 32'hF0);
        check("b2b_entry_ack", 32'(int_ack), 32'd1);
        cyc(mk(NOP, 8'h00), 8'hF0, 4'b0000, 0);
        check("b2b_in_isr", 32'(in_isr), 32'd1);
        cyc(mk(5'b10000, 8'h00), 8'hF1, 4'b0000, 0);
        check("b2b_ret2_loc", 32'(jmp_loc), 32'h31);
        check("b2b_ret2_flag", 32'(flag_restore), 32'h6);
        cyc(mk(NOP, 8'h00), 8'h31, 4'b0000, 0);
        check("third_dropped", 32'(int_ack), 32'd0);
        check("third_idle", 32'(in_isr), 32'd0);

`ifdef JIC_CALL_STACK_EN
        // Five CALLs into a 4-deep stack, then five RETs
        for (int k = 0; k < 5; k++) begin
            cyc(mk(5'b11001, 8'h20 + 8'(k)), 8'h10 + 8'(k), 4'b0000, 0);
            check("call_jumps", 32'(jmp_loc), 32'h20 + k);
        end
        cyc(mk(NOP, 8'h00), 8'h50, 4'b0000, 0);
        check("stk_err_ovf", 32'(stk_err), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc(mk(5'b11010, 8'h00), 8'h60, 4'b0000, 0);
            check("ret_lifo", 32'(jmp_loc), 32'h14 - k);
        end
        cyc(mk(5'b11010, 8'h00), 8'h61, 4'b0000, 0);
        check("ret_empty_sel", 32'(pc_mux_sel), 32'd0);
`endif

        // Reset in the middle of an ISR
        cyc(mk(NOP, 8'h00), 8'h70, 4'b1111, 1);
        cyc(mk(NOP, 8'h00), 8'hF0, 4'b0000, 0);
        check("pre_reset_isr", 32'(in_isr), 32'd1);
        @(posedge clk); #1;
        ins = '0; current_address = '0; flag_ex = '0; interrupt = 1'b0;
        reset_n = 1'b0;
        @(negedge clk); #1;
        all_zero("mid_isr_reset");
        @(posedge clk); #1; reset_n = 1'b1;
        cyc(mk(5'b10000, 8'h00), 8'h71, 4'b0000, 0);
        check("post_reset_reti", 32'(pc_mux_sel), 32'd0);
        cyc(mk(NOP, 8'h00), 8'h72, 4'b0000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
